// File: rtl/pong_pkg.sv
// Shared Pong geometry, FSM state and direction encodings.
// Also imported by pong_renderer.
package pong_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_SIZE = 10;
  localparam int PADDLE_W  = 10;
  localparam int PADDLE_H  = 60;
  localparam int PADDLEL_X = 3;
  localparam int PADDLER_X = 630;
  localparam int CX        = 315;
  localparam int CY        = 235;

  localparam int PADDLE_Y_INIT    = 210;
  localparam int PADDLE_Y_MAX     = SCREEN_H - PADDLE_H;   // 420
  localparam int BALL_Y_MAX       = SCREEN_H - BALL_SIZE;  // 470
  localparam int BALL_X_LEFT_HIT  = PADDLEL_X + PADDLE_W;  // 13
  localparam int BALL_X_RIGHT_HIT = PADDLER_X - BALL_SIZE; // 620

  typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} state_t;

  // DIR_POS is right on the x axis and down on the y axis.
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: button-driven move with clamping, plus a ball overlap test
// against the paddle's current (pre-update) position.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int PADDLE_SPEED = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_en,
  input  logic       recentre,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic [9:0] ball_y,
  output logic [9:0] y,
  output logic       overlap
);

  logic [10:0] y_ext;
  logic [10:0] ball_ext;
  logic [9:0]  y_next;

  assign y_ext    = {1'b0, y};
  assign ball_ext = {1'b0, ball_y};
  assign overlap  = (ball_ext + 11'(BALL_SIZE) > y_ext) &&
                    (ball_ext < y_ext + 11'(PADDLE_H));

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    y_next = y;
    if (btn_up && !btn_dn) begin
      // Compare before subtracting so the unsigned value never wraps.
      y_next = (y_ext < 11'(PADDLE_SPEED)) ? '0 : y - 10'(PADDLE_SPEED);
    end else if (btn_dn && !btn_up) begin
      y_next = (y_ext + 11'(PADDLE_SPEED) > 11'(PADDLE_Y_MAX)) ?
               10'(PADDLE_Y_MAX) : y + 10'(PADDLE_SPEED);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           y <= 10'(PADDLE_Y_INIT);
    else if (recentre) y <= 10'(PADDLE_Y_INIT);
    else if (move_en)  y <= y_next;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/game-over FSM and once-per-frame ball and
// paddle physics. All outputs are registered for the renderer.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_SPEED = 6,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btnL_up,
  input  logic       btnL_dn,
  input  logic       btnR_up,
  input  logic       btnR_dn,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddleL_y,
  output logic [9:0] paddleR_y,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic       game_over,
  output logic       left_win,
  output logic       right_win
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  state_t           state, state_nxt;
  dir_t             dx, dx_nxt, dy, dy_nxt;
  logic [CNT_W-1:0] serve_cnt, serve_cnt_nxt;
  logic [9:0]       ball_x_nxt, ball_y_nxt;
  logic [2:0]       scoreL_nxt, scoreR_nxt;
  logic             game_over_nxt, left_win_nxt, right_win_nxt;
  logic             point_l, point_r;
  logic             start_ev, tick_ev, paddle_en, overlap_l, overlap_r;
  logic [10:0]      bx, by;

  // A restart wins over a coincident frame tick; start is only live in GAME_OVER.
  assign start_ev  = btn_start && (state == GAME_OVER);
  assign tick_ev   = frame_tick && !start_ev;
  assign paddle_en = tick_ev && (state != GAME_OVER);
  assign bx        = {1'b0, ball_x};
  assign by        = {1'b0, ball_y};

  pong_paddle #(.PADDLE_SPEED(PADDLE_SPEED)) u_paddle_l (
    .clk(clk), .rst(rst), .move_en(paddle_en), .recentre(start_ev),
    .btn_up(btnL_up), .btn_dn(btnL_dn), .ball_y(ball_y),
    .y(paddleL_y), .overlap(overlap_l)
  );

  pong_paddle #(.PADDLE_SPEED(PADDLE_SPEED)) u_paddle_r (
    .clk(clk), .rst(rst), .move_en(paddle_en), .recentre(start_ev),
    .btn_up(btnR_up), .btn_dn(btnR_dn), .ball_y(ball_y),
    .y(paddleR_y), .overlap(overlap_r)
  );

  always_comb begin
    state_nxt     = state;
    dx_nxt        = dx;
    dy_nxt        = dy;
    serve_cnt_nxt = serve_cnt;
    ball_x_nxt    = ball_x;
    ball_y_nxt    = ball_y;
    scoreL_nxt    = scoreL;
    scoreR_nxt    = scoreR;
    game_over_nxt = game_over;
    left_win_nxt  = left_win;
    right_win_nxt = right_win;
    point_l       = 1'b0;
    point_r       = 1'b0;

    if (start_ev) begin
      state_nxt     = SERVE;
      serve_cnt_nxt = '0;
      ball_x_nxt    = 10'(CX);
      ball_y_nxt    = 10'(CY);
      dx_nxt        = DIR_POS;
      dy_nxt        = DIR_POS;
      scoreL_nxt    = '0;
      scoreR_nxt    = '0;
      game_over_nxt = 1'b0;
      left_win_nxt  = 1'b0;
      right_win_nxt = 1'b0;
    end else if (tick_ev) begin
      case (state)
        SERVE: begin
          if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            // The launch frame already takes the first step from centre.
            state_nxt     = PLAY;
            serve_cnt_nxt = '0;
            ball_x_nxt    = (dx == DIR_POS) ? 10'(CX + BALL_SPEED) : 10'(CX - BALL_SPEED);
            ball_y_nxt    = (dy == DIR_POS) ? 10'(CY + BALL_SPEED) : 10'(CY - BALL_SPEED);
          end else begin
            serve_cnt_nxt = serve_cnt + CNT_W'(1);
          end
        end

        PLAY: begin
          if (dy == DIR_NEG) begin
            if (by < 11'(BALL_SPEED)) begin
              ball_y_nxt = '0;
              dy_nxt     = DIR_POS;
            end else begin
              ball_y_nxt = ball_y - 10'(BALL_SPEED);
            end
          end else if (by + 11'(BALL_SPEED) > 11'(BALL_Y_MAX)) begin
            ball_y_nxt = 10'(BALL_Y_MAX);
            dy_nxt     = DIR_NEG;
          end else begin
            ball_y_nxt = ball_y + 10'(BALL_SPEED);
          end

          if (dx == DIR_NEG) begin
            if (bx <= 11'(BALL_X_LEFT_HIT + BALL_SPEED)) begin
              if (overlap_l) begin
                ball_x_nxt = 10'(BALL_X_LEFT_HIT);
                dx_nxt     = DIR_POS;
              end else begin
                point_r = 1'b1;
              end
            end else begin
              ball_x_nxt = ball_x - 10'(BALL_SPEED);
            end
          end else if (bx + 11'(BALL_SPEED + BALL_SIZE) >= 11'(PADDLER_X)) begin
            if (overlap_r) begin
              ball_x_nxt = 10'(BALL_X_RIGHT_HIT);
              dx_nxt     = DIR_NEG;
            end else begin
              point_l = 1'b1;
            end
          end else begin
            ball_x_nxt = ball_x + 10'(BALL_SPEED);
          end

          if (point_l || point_r) begin
            if (point_l) scoreL_nxt = sat_inc(scoreL);
            else         scoreR_nxt = sat_inc(scoreR);
            if ((point_l && scoreL_nxt == 3'(WIN_SCORE)) ||
                (point_r && scoreR_nxt == 3'(WIN_SCORE))) begin
              // Freeze the ball where the point was lost.
              state_nxt     = GAME_OVER;
              game_over_nxt = 1'b1;
              left_win_nxt  = point_l;
              right_win_nxt = point_r;
              ball_x_nxt    = ball_x;
              ball_y_nxt    = ball_y;
              dx_nxt        = dx;
              dy_nxt        = dy;
            end else begin
              state_nxt     = SERVE;
              serve_cnt_nxt = '0;
              ball_x_nxt    = 10'(CX);
              ball_y_nxt    = 10'(CY);
              dx_nxt        = point_l ? DIR_POS : DIR_NEG;
              dy_nxt        = DIR_POS;
            end
          end
        end

        GAME_OVER: ;

        default: state_nxt = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SERVE;
      serve_cnt <= '0;
      dx        <= DIR_POS;
      dy        <= DIR_POS;
      ball_x    <= 10'(CX);
      ball_y    <= 10'(CY);
      scoreL    <= '0;
      scoreR    <= '0;
      game_over <= 1'b0;
      left_win  <= 1'b0;
      right_win <= 1'b0;
    end else begin
      state     <= state_nxt;
      serve_cnt <= serve_cnt_nxt;
      dx        <= dx_nxt;
      dy        <= dy_nxt;
      ball_x    <= ball_x_nxt;
      ball_y    <= ball_y_nxt;
      scoreL    <= scoreL_nxt;
      scoreR    <= scoreR_nxt;
      game_over <= game_over_nxt;
      left_win  <= left_win_nxt;
      right_win <= right_win_nxt;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a scripted game with hand-traced ball
// trajectories, paddle limits, scoring, game over and restart.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, btn_start;
  logic       btnL_up, btnL_dn, btnR_up, btnR_dn;
  logic [9:0] ball_x, ball_y, paddleL_y, paddleR_y;
  logic [2:0] scoreL, scoreR;
  logic       game_over, left_win, right_win;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btnL_up(btnL_up), .btnL_dn(btnL_dn), .btnR_up(btnR_up), .btnR_dn(btnR_dn),
    .btn_start(btn_start),
    .ball_x(ball_x), .ball_y(ball_y), .paddleL_y(paddleL_y), .paddleR_y(paddleR_y),
    .scoreL(scoreL), .scoreR(scoreR),
    .game_over(game_over), .left_win(left_win), .right_win(right_win)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, ".ball_x"}, 32'(ball_x), 32'(x));
    check({tag, ".ball_y"}, 32'(ball_y), 32'(y));
  endtask

  task automatic check_paddles(input string tag, input int l, input int r);
    check({tag, ".paddleL_y"}, 32'(paddleL_y), 32'(l));
    check({tag, ".paddleR_y"}, 32'(paddleR_y), 32'(r));
  endtask

  task automatic check_status(input string tag, input int sl, input int sr,
                              input bit go, input bit lw, input bit rw);
    check({tag, ".scoreL"},    32'(scoreL),    32'(sl));
    check({tag, ".scoreR"},    32'(scoreR),    32'(sr));
    check({tag, ".game_over"}, 32'(game_over), 32'(go));
    check({tag, ".left_win"},  32'(left_win),  32'(lw));
    check({tag, ".right_win"}, 32'(right_win), 32'(rw));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0; btn_start = 1'b0;
    btnL_up = 1'b0; btnL_dn = 1'b0; btnR_up = 1'b0; btnR_dn = 1'b0;
    repeat (3) @(negedge clk);
    check_ball("reset", 315, 235);
    check_paddles("reset", 210, 210);
    check_status("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Serve period: left paddle clamps at 0, right paddle holds with both buttons.
    btnL_up = 1'b1; btnR_up = 1'b1; btnR_dn = 1'b1;
    ticks(35);
    check_paddles("l_up35", 0, 210);
    ticks(5);
    check_paddles("l_up40", 0, 210);
    btnL_up = 1'b0; btnL_dn = 1'b1; btnR_up = 1'b0;
    ticks(19);                                   // tick 59
    check_ball("serve59", 315, 235);
    check_paddles("dn19", 114, 324);
    ticks(1);                                    // tick 60: launch
    check_ball("launch", 319, 239);
    ticks(1);                                    // tick 61
    check_ball("play61", 323, 243);
    ticks(5);                                    // tick 66
    btnR_dn = 1'b0;
    check_paddles("dn26", 156, 366);
    ticks(4);                                    // tick 70
    btnL_dn = 1'b0;
    check_paddles("dn30", 180, 366);

    // Bottom wall bounce.
    ticks(47);                                   // tick 117
    check("pre_bottom.ball_y", 32'(ball_y), 32'd467);
    ticks(1);
    check_ball("bottom_clamp", 551, 470);
    ticks(1);
    check("bottom_up.ball_y", 32'(ball_y), 32'd466);

    // Right paddle bounce.
    ticks(16);                                   // tick 135
    check_ball("pre_rhit", 619, 402);
    ticks(1);
    check_ball("rhit", 620, 398);
    ticks(1);
    check("after_rhit.ball_x", 32'(ball_x), 32'd616);

    // Top wall bounce on the way, then left paddle bounce.
    ticks(150);                                  // tick 287
    check_ball("pre_lhit", 16, 204);
    ticks(1);
    check_ball("lhit", 13, 208);
    ticks(1);
    check_ball("after_lhit", 17, 212);

    // Right paddle misses: left scores, serve goes right again.
    ticks(150);                                  // tick 439
    check_ball("pre_rmiss", 617, 130);
    ticks(1);
    check_ball("rmiss", 315, 235);
    check_status("rmiss", 1, 0, 0, 0, 0);

    // Round 2: move left paddle to 0 so the return is missed.
    btnL_up = 1'b1;
    ticks(30);                                   // tick 470
    btnL_up = 1'b0;
    check_paddles("r2_move", 0, 366);
    ticks(30);                                   // tick 500: launch right
    check_ball("r2_launch", 319, 239);
    ticks(227);                                  // tick 727
    check_ball("pre_lmiss", 16, 204);
    ticks(1);
    check_ball("lmiss", 315, 235);
    check_status("lmiss", 1, 1, 0, 0, 0);
    ticks(60);                                   // serve toward the left player
    check_ball("r3_launch", 311, 239);

    // Asynchronous reset mid-game.
    ticks(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ball("mid_reset", 315, 235);
    check_paddles("mid_reset", 210, 210);
    check_status("mid_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Right paddle at 210 misses every right-launched serve.
    ticks(6 * 136);
    check_status("six_pts", 6, 0, 0, 0, 0);
    check_ball("six_pts", 315, 235);
    ticks(136);
    check_status("win", 7, 0, 1, 1, 0);

    // Frozen in GAME_OVER.
    btnL_dn = 1'b1; btnR_up = 1'b1;
    ticks(5);
    btnL_dn = 1'b0; btnR_up = 1'b0;
    check_paddles("frozen", 210, 210);
    check_status("frozen", 7, 0, 1, 1, 0);

    // Restart coincident with a frame tick: the tick must not count.
    @(negedge clk);
    btn_start = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    btn_start = 1'b0; frame_tick = 1'b0;
    check_status("restart", 0, 0, 0, 0, 0);
    check_ball("restart", 315, 235);
    check_paddles("restart", 210, 210);

    // btn_start during SERVE is ignored: launch still on the 60th tick.
    ticks(30);
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    ticks(29);
    check_ball("rs_serve59", 315, 235);
    ticks(1);
    check_ball("rs_launch", 319, 239);
    check_status("rs_launch", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller that owns all Pong game state and drives the renderer's inputs. These are ball position, paddle positions, scores, game_over, left_win and right_win. It advances physics once per video frame on a one-cycle frame_tick from VGA timing, and runs the serve / play / point / game-over state machine. All outputs are registered and change only on frame_tick or btn_start, so the renderer sees stable values across a frame.

Parameters:
BALL_SPEED, 4, ball pixels per frame on each axis
PADDLE_SPEED, 6, paddle pixels per frame
SERVE_FRAMES, 60, frame ticks the ball is held at centre before moving
WIN_SCORE, 7, score that ends the game (legal range 1..7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
btnL_up, btnL_dn, btnR_up, btnR_dn  in  1 each  synchronised paddle buttons, level-sensitive
btn_start  in  1  synchronised one-cycle restart pulse
ball_x, ball_y  out  10  ball top-left position
paddleL_y, paddleR_y  out  10  paddle top positions
scoreL, scoreR  out  3  scores
game_over, left_win, right_win  out  1 each  end-of-game flags

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high, on rst.
- Geometry is fixed: screen 640x480, BALL_SIZE 10, PADDLE_W 10, PADDLE_H 60, PADDLEL_X 3, PADDLER_X 630, CX 315, CY 235.
- Reset values: ball (315,235); both paddles 210; scores 0; game_over, left_win and right_win all 0; state SERVE; serve counter 0; ball dx = +1 (right); dy = +1 (down).
- States:
  - SERVE: ball held at (CX,CY). Each frame_tick increments the counter. On the tick that makes the counter SERVE_FRAMES, go to PLAY and clear the counter. Paddles move in SERVE.
  - PLAY: all updates below happen on frame_tick only.
  - GAME_OVER: everything frozen. game_over=1, and the winner flag is held. btn_start clears the scores and flags, recentres the ball and paddles (210), and enters SERVE with dx=+1. btn_start is ignored in all other states.
- Paddles (SERVE and PLAY), each side independently:
  - up only: y = max(y-PADDLE_SPEED, 0)
  - down only: y = min(y+PADDLE_SPEED, 420)
  - both or neither: hold
  - Subtraction is underflow-safe: compare before subtracting.
- Ball Y (PLAY):
  - moving up and ball_y < BALL_SPEED: ball_y=0, dy=down
  - moving down and ball_y+BALL_SPEED > 470: ball_y=470, dy=up
  - otherwise ball_y ± BALL_SPEED
- Ball X (PLAY):
  - Overlap tests use the pre-update ball_y and paddle_y of this frame: overlap = ball_y+10 > paddle_y && ball_y < paddle_y+60.
  - Left-moving, ball_x <= 13+BALL_SPEED: if overlap, ball_x=13 and dx=right; else right scores.
  - Right-moving, ball_x+BALL_SPEED+10 >= 630: if overlap, ball_x=620 and dx=left; else left scores.
  - Otherwise ball_x ± BALL_SPEED.
  - The Y update is applied in the same frame as any X bounce.
- Point (same tick as detection):
  - Scorer's score increments; the 3-bit counter saturates at 7.
  - If the new score equals WIN_SCORE: go to GAME_OVER and set left_win or right_win.
  - Otherwise go to SERVE: ball to centre, counter 0, dx toward the player who conceded, dy=down.
- Only one scorer is possible per tick.
- frame_tick and btn_start in the same cycle: btn_start is processed; frame_tick is ignored that cycle.
- Reset mid-game or mid-serve returns immediately to the reset values.
- Internal arithmetic is 11 bits; no output ever leaves its range (ball_x 0..630, ball_y 0..470, paddles 0..420).

Decomposition:
- pong_pkg holds:
  - screen, ball and paddle geometry constants, also imported by pong_renderer
  - the state enum {SERVE, PLAY, GAME_OVER}
  - direction encoding
- One sub-module, pong_paddle, instantiated twice. It handles move, clamp and the both-buttons hold, and provides an overlap output for a given ball_y.

Test Plan:
- Reset → ball (315,235), paddles 210/210, scores 0/0, flags 0. After 60 ticks ball_x=319; after 61, ball_y=243.
- btnL_up held for 40 ticks from paddleL_y=210 → 0 after 35 ticks, no wrap. Both buttons held → unchanged.
- Ball_y=468 moving down, tick → 470 with dy up; next tick → 466.
- PaddleL_y=200, ball (16,230) moving left, tick → ball_x=13, dx right; next tick → 17.
- PaddleL_y=0, ball (15,300) moving left, tick → scoreR=1, ball (315,235), SERVE. After 60 ticks ball_x=311 (moving left).
- scoreL=6 and the right paddle misses → scoreL=7, game_over=1, left_win=1, outputs frozen on further ticks. btn_start → scores 0, flags 0, SERVE.
